// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-step controller for the 4-bit combinational shifter. It latches one
//   command (mode, repeat count, operand). It then applies the selected shifter
//   mode once per clock for `count` cycles, feeding each result back as the next
//   operand. The final value is presented on dout together with a one-cycle done
//   pulse.
//
//   Optional feature: define SHIFT_SEQ_ABORT_EN to add the `abort` input, which
//   cancels a running command (SHIFT state only) without a done pulse.
//
// Parameters:
//   COUNT_W  width of the repeat-count field (max shifts = 2^COUNT_W - 1)
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   start    command strobe, sampled only in IDLE
//   mode     shifter mode for this command
//   count    number of shift steps (0 = pass din straight through)
//   din      initial operand
//   sh_a     operand to the shifter (tap of the data register)
//   sh_mode  mode to the shifter (tap of the latched mode register)
//   sh_r     shifter result, combinational from sh_a/sh_mode
//   abort    (SHIFT_SEQ_ABORT_EN only) cancel the running command
//   busy     high in SHIFT and DONE
//   done     one-cycle pulse, dout valid in the same cycle
//   dout     final result, held until the next command's done
module shift_sequencer #(
  parameter int COUNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [COUNT_W-1:0] count,
  input  logic [3:0]         din,
  output logic [3:0]         sh_a,
  output logic [2:0]         sh_mode,
  input  logic [3:0]         sh_r,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic [3:0]         dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         data;
  logic [2:0]         mode_r;
  logic [COUNT_W-1:0] cnt;

  // The shifter sees the registers directly; its result comes back on sh_r
  // within the same cycle.
  assign sh_a    = data;
  assign sh_mode = mode_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      data   <= '0;
      mode_r <= '0;
      cnt    <= '0;
      dout   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data   <= din;
            mode_r <= mode;
            cnt    <= count;
            busy   <= 1'b1;
            if (count != '0) begin
              state <= SHIFT;
            end else begin
              // Zero-length command: skip SHIFT, the operand is the result.
              state <= DONE;
              done  <= 1'b1;
              dout  <= din;
            end
          end
        end

        SHIFT: begin
`ifdef SHIFT_SEQ_ABORT_EN
          if (abort) begin
            // Cancel wins over the final-step exit; dout keeps the last result.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else
`endif
          begin
            data <= sh_r;
            cnt  <= cnt - COUNT_W'(1);
            // Exit on cnt == 1 so the counter never wraps; dout captures the
            // final shifter result so it is valid alongside done.
            if (cnt == COUNT_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              dout  <= sh_r;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int CW = 3;
  localparam int TIMEOUT = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] count;
  logic [3:0]    din;
  logic [3:0]    sh_a;
  logic [2:0]    sh_mode;
  logic [3:0]    sh_r;
  logic          busy;
  logic          done;
  logic [3:0]    dout;
`ifdef SHIFT_SEQ_ABORT_EN
  logic          abort;
`endif

  int passed = 0;
  int total  = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // Model of the team's shifter:
  // 000 shl 0-fill, 001 shl 1-fill, 010 shr 0-fill, 011 shr 1-fill,
  // 1x0 rotate left, 1x1 rotate right.
  function automatic logic [3:0] shf(input logic [3:0] a, input logic [2:0] m);
    case (m)
      3'b000:        return {a[2:0], 1'b0};
      3'b001:        return {a[2:0], 1'b1};
      3'b010:        return {1'b0, a[3:1]};
      3'b011:        return {1'b1, a[3:1]};
      3'b100, 3'b110: return {a[2:0], a[3]};
      default:       return {a[0], a[3:1]};
    endcase
  endfunction

  function automatic logic [3:0] ref_run(input logic [3:0] d, input logic [2:0] m,
                                         input int n);
    logic [3:0] v;
    v = d;
    for (int i = 0; i < n; i++) v = shf(v, m);
    return v;
  endfunction

  assign sh_r = shf(sh_a, sh_mode);

  shift_sequencer #(.COUNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .count  (count),
    .din    (din),
    .sh_a   (sh_a),
    .sh_mode(sh_mode),
    .sh_r   (sh_r),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort  (abort),
`endif
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  // Called 1 time unit after a rising edge. Returns 1 time unit after the
  // sampling edge (cycle 1 of the command); inputs are scrambled afterwards.
  task automatic issue(input logic [2:0] m, input logic [CW-1:0] c, input logic [3:0] d);
    start = 1'b1; mode = m; count = c; din = d;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 3'($urandom);
    count = CW'($urandom);
    din   = 4'($urandom);
  endtask

  // Advance until done is seen or the budget expires; cyc is the cycle index
  // in which done was observed (TIMEOUT on expiry).
  task automatic wait_done(input int first, output int cyc, output bit busy_ok);
    cyc = first;
    busy_ok = 1'b1;
    while (!done && cyc < TIMEOUT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = '0; count = '0; din = '0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({sh_a, sh_mode, busy, done, dout} !== 13'd0)
      $display("FAIL reset_outputs: got sh_a=%b sh_mode=%b busy=%b done=%b dout=%b, want all 0",
               sh_a, sh_mode, busy, done, dout);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_shift();
    logic [2:0]    tm[7] = '{3'b000, 3'b011, 3'b110, 3'b001, 3'b010, 3'b101, 3'b111};
    logic [CW-1:0] tc[7] = '{3'd2, 3'd1, 3'd4, 3'd7, 3'd3, 3'd5, 3'd6};
    logic [3:0]    td[7] = '{4'b1011, 4'b0010, 4'b1011, 4'b0101, 4'b1100, 4'b1001, 4'b0110};
    int cyc;
    bit bok;
    logic [3:0] exp;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(ref_run(td[i], tm[i], int'(tc[i])));
      issue(tm[i], tc[i], td[i]);
      total++;
      if (sh_a !== td[i] || sh_mode !== tm[i])
        $display("FAIL shift_latch[%0d]: got sh_a=%b sh_mode=%b, want %b %b",
                 i, sh_a, sh_mode, td[i], tm[i]);
      else passed++;
      wait_done(1, cyc, bok);
      total++;
      if (cyc !== int'(tc[i]) + 1 || !bok)
        $display("FAIL shift_latency[%0d]: got done cycle %0d busy_ok=%0b, want cycle %0d busy_ok=1",
                 i, cyc, bok, int'(tc[i]) + 1);
      else passed++;
      exp = exp_q.pop_front();
      total++;
      if (done !== 1'b1 || dout !== exp)
        $display("FAIL shift_result[%0d]: got done=%b dout=%b, want 1 %b", i, done, dout, exp);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || dout !== exp)
        $display("FAIL shift_after[%0d]: got done=%b busy=%b dout=%b, want 0 0 %b",
                 i, done, busy, dout, exp);
      else passed++;
    end
  endtask

  task automatic test_zero_count();
    int cyc;
    bit bok;
    logic [3:0] exp;
    exp_q.push_back(4'b0110);
    issue(3'b101, 3'd0, 4'b0110);
    wait_done(1, cyc, bok);
    exp = exp_q.pop_front();
    total++;
    if (cyc !== 1 || !bok || dout !== exp)
      $display("FAIL zero_count: got cycle %0d busy_ok=%0b dout=%b, want cycle 1 busy_ok=1 dout=%b",
               cyc, bok, dout, exp);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL zero_count_idle: got busy=%b done=%b, want 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit bok;
    logic [3:0] exp;
    exp_q.push_back(4'b1000);
    issue(3'b000, 3'd3, 4'b1011);
    // Second strobe while busy must be ignored.
    start = 1'b1; din = 4'b1111; mode = 3'b001; count = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, cyc, bok);
    exp = exp_q.pop_front();
    total++;
    if (cyc !== 4 || !bok || dout !== exp)
      $display("FAIL ignore_start: got cycle %0d busy_ok=%0b dout=%b, want cycle 4 busy_ok=1 dout=%b",
               cyc, bok, dout, exp);
    else passed++;
    @(posedge clk); #1;
    // First cycle after done: a new command is accepted.
    exp_q.push_back(4'b1001);
    issue(3'b011, 3'd1, 4'b0010);
    wait_done(1, cyc, bok);
    exp = exp_q.pop_front();
    total++;
    if (cyc !== 2 || !bok || dout !== exp)
      $display("FAIL back_to_back: got cycle %0d busy_ok=%0b dout=%b, want cycle 2 busy_ok=1 dout=%b",
               cyc, bok, dout, exp);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int cyc;
    bit bok;
    logic [3:0] exp;
    issue(3'b001, 3'd5, 4'b1011);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b1)
      $display("FAIL reset_mid_busy: got busy=%b, want 1", busy);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({sh_a, sh_mode, busy, done, dout} !== 13'd0)
      $display("FAIL reset_mid_outputs: got sh_a=%b sh_mode=%b busy=%b done=%b dout=%b, want all 0",
               sh_a, sh_mode, busy, done, dout);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen)
      $display("FAIL reset_mid_quiet: got activity after reset, want idle");
    else passed++;
    exp_q.push_back(ref_run(4'b0101, 3'b100, 3));
    issue(3'b100, 3'd3, 4'b0101);
    wait_done(1, cyc, bok);
    exp = exp_q.pop_front();
    total++;
    if (cyc !== 4 || dout !== exp)
      $display("FAIL reset_mid_recover: got cycle %0d dout=%b, want cycle 4 dout=%b", cyc, dout, exp);
    else passed++;
    @(posedge clk); #1;
  endtask

`ifdef SHIFT_SEQ_ABORT_EN
  task automatic test_abort();
    bit seen;
    int cyc;
    bit bok;
    logic [3:0] prev;
    logic [3:0] exp;
    prev = dout;
    issue(3'b000, 3'd5, 4'b1111);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || dout !== prev)
      $display("FAIL abort: got busy=%b done=%b dout=%b, want 0 0 %b", busy, done, dout, prev);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || dout !== prev) seen = 1'b1;
    end
    total++;
    if (seen)
      $display("FAIL abort_quiet: got done or dout change after abort, want none");
    else passed++;
    exp_q.push_back(ref_run(4'b0011, 3'b101, 2));
    issue(3'b101, 3'd2, 4'b0011);
    wait_done(1, cyc, bok);
    exp = exp_q.pop_front();
    total++;
    if (cyc !== 3 || dout !== exp)
      $display("FAIL abort_recover: got cycle %0d dout=%b, want cycle 3 dout=%b", cyc, dout, exp);
    else passed++;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_shift();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
`ifdef SHIFT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-step controller for the team's 4-bit combinational shifter (8 modes: shift left or right with 0 or 1 fill, rotate left or right).
- Accepts one command (mode, repeat count, operand) and applies the selected shifter mode once per clock for `count` cycles.
- Feeds each shifter result back as the next operand, then presents the final value with a one-cycle done pulse.
- Sits between command-issuing logic (counter or exercise top level) and a single shifter instance.

Parameters:
- COUNT_W, 3, width of the repeat-count field; max shifts per command = 2^COUNT_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  3  shifter mode for this command.
- count  input  COUNT_W  number of shift steps.
- din  input  4  initial operand.
- sh_a  output  4  operand driven to the shifter (equals internal data register).
- sh_mode  output  3  mode driven to the shifter (equals latched mode register).
- sh_r  input  4  shifter result, combinational from sh_a/sh_mode.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse when result is valid.
- dout  output  4  final result; held until the next command's done.

Behaviour:
- Reset: async, active-high, immediate.
  - State to IDLE.
  - data, mode_r, cnt, dout cleared to 0.
  - busy = 0, done = 0, so sh_a = 0 and sh_mode = 000.
- States: IDLE, SHIFT, DONE. All outputs are registered except sh_a and sh_mode, which are direct register taps.
- IDLE:
  - On start = 1: data <= din, mode_r <= mode, cnt <= count.
  - Next state is SHIFT if count != 0, else DONE.
  - start = 0: remain in IDLE.
- SHIFT, each cycle: data <= sh_r, cnt <= cnt - 1.
  - When cnt == 1, the last shift is taken this cycle and next state is DONE.
  - Otherwise stay in SHIFT.
- DONE, for one cycle:
  - done = 1 and dout = data.
  - dout is registered on entry, so it is valid in the same cycle done is high.
  - Next state is IDLE.
- Latency: start sampled at edge 0; done high during cycle count+1 (count = 0 gives done in cycle 1, with dout = din).
- Throughput: a new start is accepted in the cycle after done; back-to-back commands need count+2 cycles each.
- start while busy is ignored; no queueing, no error flag.
- mode, count and din are don't-care outside the start cycle; the latched copies are used for the whole command.
- cnt never underflows: the SHIFT exit occurs at cnt == 1, and count == 0 bypasses SHIFT.
- Reset mid-operation aborts immediately with no done pulse; dout returns to 0.
- dout changes only on entry to DONE (or on reset).

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit), checked in SHIFT only.
  - abort = 1 in SHIFT: next state is IDLE, cnt is cleared, no done pulse, dout unchanged.
  - abort has priority over the cnt == 1 exit.
  - abort in IDLE or DONE has no effect.
- When not defined: no abort port; commands always run to completion.

Test Plan:
- Shift left, 0 fill: din=1011, mode=000, count=2 -> done in cycle 3, dout=1100, busy high cycles 1-3.
- Shift right, 1 fill: din=0010, mode=011, count=1 -> done in cycle 2, dout=1001. Rotate: din=1011, mode=110, count=4 -> dout=1011.
- Zero count: din=0110, mode=101, count=0 -> done in cycle 1, dout=0110, SHIFT never entered.
- start pulsed during SHIFT with din=1111 -> ignored; result matches the first command. Back-to-back start in the cycle after done is accepted.
- rst asserted mid-SHIFT (din=1011, mode=001, count=5, rst at cycle 3) -> outputs 0 immediately, no done, IDLE after release.
- With SHIFT_SEQ_ABORT_EN: abort at cycle 2 of count=5 -> no done, dout keeps the previous result, next command runs normally.
